// File: rtl/frame_playback_streamer_pkg.sv
// Shared types and default sizes for the frame playback streamer.
package frame_playback_streamer_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/frame_playback_streamer_if.sv
// Valid/ready sample stream towards the I2S/DAC transmitter.
interface frame_playback_streamer_if
    import frame_playback_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/frame_playback_streamer_fifo.sv
// Synchronous prefetch FIFO; the head comes straight from registered storage, so a
// push becomes visible at the output on the following cycle.
module frame_playback_streamer_fifo
    import frame_playback_streamer_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == LP_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop_ok) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/frame_playback_streamer.sv
// Reads a finished frame from the filter RAM and streams it out through a prefetch FIFO.
//  state | meaning
//  IDLE  | waiting for frame_done
//  FETCH | issuing RAM reads 0..len while FIFO credit allows
//  DRAIN | all reads issued, waiting for the m_last handshake
module frame_playback_streamer
    import frame_playback_streamer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_done,
    input  logic [ADDR_WIDTH-1:0]     i_frame_len_max,
    output logic [ADDR_WIDTH-1:0]     o_rd_addr,
    input  logic [DATA_WIDTH-1:0]     i_rd_data,
    frame_playback_streamer_if.master m,
    output logic                      o_busy,
    output logic                      o_overrun
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] LP_DEPTH = (CW+1)'(FIFO_DEPTH);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  w_issue;
    logic                  w_start;
    logic                  w_last_issue;
    logic                  w_pop;
    logic [CW:0]           w_pending;
    logic [DATA_WIDTH:0]   w_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CW-1:0]         w_fifo_count;

    // Credit counts the read still in flight, so the FIFO can never be overfilled.
    assign w_pending    = {1'b0, w_fifo_count} + {{CW{1'b0}}, r_inflight};
    assign w_last_issue = (r_addr == r_len);
    assign w_pop        = m.valid && m.ready;
    assign o_rd_addr    = r_addr;

    assign m.valid = !w_fifo_empty;
    assign m.data  = w_fifo_empty ? '0 : w_head[DATA_WIDTH-1:0];
    assign m.last  = !w_fifo_empty && w_head[DATA_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_frame_done) w_state_nxt = ST_FETCH;
            ST_FETCH: if (w_issue && w_last_issue) w_state_nxt = ST_DRAIN;
            // The tagged last word is the final entry, so its handshake empties the pipe.
            ST_DRAIN: if (w_pop && m.last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue   = 1'b0;
        w_start   = 1'b0;
        o_busy    = (r_state != ST_IDLE);
        o_overrun = i_frame_done && (r_state != ST_IDLE);
        if (r_state == ST_FETCH) w_issue = (w_pending < LP_DEPTH) && !w_fifo_full;
        if (r_state == ST_IDLE)  w_start = i_frame_done;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len           <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && w_last_issue;
            if (w_start) begin
                r_len  <= i_frame_len_max;
                r_addr <= '0;
            end else if (w_issue && !w_last_issue) begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    frame_playback_streamer_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_last, i_rd_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

endmodule

// File: tb/tb_frame_playback_streamer.sv
// Directed bench for frame_playback_streamer with a queue-based model of the expected stream.
module tb_frame_playback_streamer;
    import frame_playback_streamer_pkg::*;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int FD = 4;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_done = 1'b0;
    logic [AW-1:0] frame_len_max = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data = '0;
    logic          busy;
    logic          overrun;
    logic [DW-1:0] ram [1<<AW];

    frame_playback_streamer_if #(.DATA_WIDTH(DW)) s_if ();

    frame_playback_streamer #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_frame_done    (frame_done),
        .i_frame_len_max (frame_len_max),
        .o_rd_addr       (rd_addr),
        .i_rd_data       (rd_data),
        .m               (s_if),
        .o_busy          (busy),
        .o_overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= ram[rd_addr];

    int            n_vec = 0;
    int            n_err = 0;
    exp_t          q[$];
    bit            mbusy = 1'b0;
    bit            nbusy;
    int            f_samples = 0;
    int            f_lasts = 0;
    int            f_maxaddr = 0;
    int            f_prevaddr = 0;
    logic [DW-1:0] f_lastdata = '0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected stream: on an accepted frame_done the whole frame ram[0..len] is queued.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            mbusy      = 1'b0;
            stall_prev = 1'b0;
        end else begin
            nbusy = mbusy;
            chk("busy", busy, mbusy);
            chk("overrun", overrun, frame_done && mbusy);
            if (stall_prev) begin
                chk("stall_valid", s_if.valid, 1);
                chk("stall_data", s_if.data, prev_d);
                chk("stall_last", s_if.last, prev_l);
            end
            if (s_if.valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", s_if.valid, 0);
                end else if (s_if.ready) begin
                    chk("data", s_if.data, q[0].d);
                    chk("last", s_if.last, q[0].l);
                    f_samples++;
                    if (s_if.last) begin
                        f_lasts++;
                        f_lastdata = s_if.data;
                    end
                    if (q[0].l) nbusy = 1'b0;
                    void'(q.pop_front());
                end
            end
            if (mbusy) begin
                chk("addr_credit", int'(rd_addr) <= f_samples + FD, 1);
                chk("addr_monotonic", int'(rd_addr) >= f_prevaddr, 1);
                f_prevaddr = int'(rd_addr);
                if (int'(rd_addr) > f_maxaddr) f_maxaddr = int'(rd_addr);
            end
            stall_prev = s_if.valid && !s_if.ready;
            prev_d     = s_if.data;
            prev_l     = s_if.last;
            if (frame_done && !mbusy) begin
                for (int a = 0; a <= int'(frame_len_max); a++) begin
                    q.push_back('{ram[a], (a == int'(frame_len_max))});
                end
                nbusy      = 1'b1;
                f_samples  = 0;
                f_lasts    = 0;
                f_maxaddr  = 0;
                f_prevaddr = 0;
            end
            mbusy = nbusy;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len);
        frame_len_max = AW'(len);
        frame_done    = 1'b1;
        cyc();
        frame_done    = 1'b0;
    endtask

    task automatic wait_idle(input int mode, input int max, input string nm);
        int k;
        k = 0;
        while (busy && k < max) begin
            case (mode)
                1:       s_if.ready = (k % 4 == 0) || (k % 4 == 3);
                default: s_if.ready = 1'b1;
            endcase
            cyc();
            k++;
        end
        chk({nm, "_timeout"}, busy, 0);
        s_if.ready = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int k;
        for (int a = 0; a < (1 << AW); a++) ram[a] = 16'(a * 257) ^ 16'h5A5A;
        s_if.ready = 1'b1;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        chk("rst_valid", s_if.valid, 0);
        chk("rst_data", s_if.data, 0);
        chk("rst_last", s_if.last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_addr", rd_addr, 0);
        cyc();

        // 1: 8 samples, ready high, first valid three cycles after frame_done
        start_frame(7);
        lat = 1;
        while (!s_if.valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("t1_latency", lat, 3);
        chk("t1_first_data", s_if.data, 16'h5A5A);
        wait_idle(0, 50, "t1");
        chk("t1_samples", f_samples, 8);
        chk("t1_lasts", f_lasts, 1);
        chk("t1_last_data", f_lastdata, 16'h5D5D);
        cyc();
        chk("t1_busy_after", busy, 0);

        // 2: ready pattern 1,0,0,1
        start_frame(7);
        wait_idle(1, 100, "t2");
        chk("t2_samples", f_samples, 8);
        chk("t2_lasts", f_lasts, 1);
        cyc();

        // 3: sink stalled for 20 cycles
        s_if.ready = 1'b0;
        start_frame(7);
        repeat (9) cyc();
        chk("t3_addr_c10", rd_addr, FD);
        repeat (10) cyc();
        chk("t3_addr_c20", rd_addr, FD);
        chk("t3_valid", s_if.valid, 1);
        chk("t3_head", s_if.data, 16'h5A5A);
        wait_idle(0, 50, "t3");
        chk("t3_samples", f_samples, 8);
        cyc();

        // 4: single-sample and full-size frames
        start_frame(0);
        wait_idle(0, 20, "t4a");
        chk("t4a_samples", f_samples, 1);
        chk("t4a_lasts", f_lasts, 1);
        chk("t4a_data", f_lastdata, 16'h5A5A);
        cyc();
        start_frame(1023);
        wait_idle(0, 1200, "t4b");
        chk("t4b_samples", f_samples, 1024);
        chk("t4b_maxaddr", f_maxaddr, 1023);
        chk("t4b_last_data", f_lastdata, 16'h58A5);
        cyc();

        // 5: frame_done while busy, including on the final handshake
        start_frame(7);
        k = 0;
        while (f_samples < 3 && k < 20) begin cyc(); k++; end
        chk("t5_reach_s3", f_samples >= 3, 1);
        frame_done = 1'b1;
        #1;
        chk("t5_overrun_mid", overrun, 1);
        cyc();
        frame_done = 1'b0;
        k = 0;
        while (!(s_if.valid && s_if.last) && k < 20) begin cyc(); k++; end
        chk("t5_reach_last", s_if.valid && s_if.last, 1);
        frame_done = 1'b1;
        #1;
        chk("t5_overrun_edge", overrun, 1);
        cyc();
        frame_done = 1'b0;
        chk("t5_busy_fell", busy, 0);
        cyc();
        chk("t5_no_restart", busy, 0);
        chk("t5_samples", f_samples, 8);
        start_frame(7);
        wait_idle(0, 50, "t5b");
        chk("t5b_samples", f_samples, 8);
        cyc();

        // 6: reset mid-frame then restart
        start_frame(7);
        k = 0;
        while (f_samples < 4 && k < 20) begin cyc(); k++; end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("t6_valid", s_if.valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_addr", rd_addr, 0);
        cyc();
        start_frame(7);
        wait_idle(0, 50, "t6b");
        chk("t6b_samples", f_samples, 8);
        chk("t6b_lasts", f_lasts, 1);
        repeat (2) cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
